load_hazard_scoreboard: RTL

Parametrised load-use hazard unit for the IITB-RISC pipeline. It replaces single-cycle, single-destination bubble detection with a per-register countdown scoreboard. The scoreboard covers configurable load latency and LM (load-multiple) sequences that write one register per cycle. It sits beside the ID stage: it records load issues arriving from the RR/EX boundary and drives `stall_o` to freeze IF/ID and insert a bubble into RR.

---
 rtl/iitb_pkg.sv | 29 ++
 rtl/lm_rank.sv | 20 ++
 rtl/load_hazard_scoreboard.sv | 92 +++++++++
 3 files changed

// File: rtl/iitb_pkg.sv
// Shared IITB-RISC decode helpers: opcode encodings and per-opcode source-field usage.
package iitb_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    // Returns {use_rs1, use_rs2}; unlisted opcodes read no registers.
    function automatic logic [1:0] src_use(input logic [3:0] opcode);
        logic [1:0] u;
        u = 2'b00;
        case (opcode)
            OP_ADI, OP_LW, OP_SW, OP_JLR:    u = 2'b10;
            OP_LM:                           u = 2'b01;
            OP_ADD, OP_NAND, OP_SM, OP_BEQ:  u = 2'b11;
            default:                         u = 2'b00;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/lm_rank.sv
// Prefix popcount of an LM register list: rank[k] = number of set mask bits below k.
module lm_rank #(
    parameter int NREGS = 8,
    parameter int REG_W = 3
) (
    input  logic [NREGS-1:0]            mask,
    output logic [NREGS-1:0][REG_W-1:0] rank
);

    always_comb begin
        logic [REG_W-1:0] acc;
        acc  = '0;
        rank = '0;
        for (int k = 0; k < NREGS; k++) begin
            rank[k] = acc;
            acc     = acc + REG_W'(mask[k]);
        end
    end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Per-register countdown scoreboard for LW/LM load-use stalls beside the ID stage.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module load_hazard_scoreboard
    import iitb_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int REG_W    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             iss_valid,
    input  logic             iss_is_lm,
    input  logic [REG_W-1:0] iss_rd,
    input  logic [NREGS-1:0] iss_mask,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [NREGS-1:0] pending_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(LOAD_LAT + NREGS + 1);

    logic [CNT_W-1:0]            cnt      [NREGS];
    logic [CNT_W-1:0]            eff      [NREGS];
    logic [CNT_W-1:0]            cnt_nxt  [NREGS];
    logic [NREGS-1:0][REG_W-1:0] rank;
    logic                        issue;
    logic [1:0]                  use_src;

    lm_rank #(.NREGS(NREGS), .REG_W(REG_W)) u_lm_rank (
        .mask (iss_mask),
        .rank (rank)
    );

    assign issue = iss_valid && !flush_i;

    // The same-cycle issue is folded into eff so a dependent already in ID sees it.
    always_comb begin
        logic [CNT_W-1:0] hz;
        for (int k = 0; k < NREGS; k++) begin
            hz = '0;
            if (issue) begin
                if (iss_is_lm) begin
                    if (iss_mask[k])
                        hz = CNT_W'(LOAD_LAT) + CNT_W'(rank[k]);
                end else if (iss_rd == REG_W'(k)) begin
                    hz = CNT_W'(LOAD_LAT);
                end
            end
            eff[k]     = (hz > cnt[k]) ? hz : cnt[k];
            cnt_nxt[k] = (eff[k] != '0) ? eff[k] - CNT_W'(1) : '0;
        end
    end

    always_comb begin
        use_src = src_use(id_opcode);
        stall_o = (use_src[1] && (eff[id_rs1] != '0)) ||
                  (use_src[0] && (eff[id_rs2] != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++)
                cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++)
                cnt[k] <= cnt_nxt[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NREGS; k++)
            pending_o[k] = (cnt[k] != '0);
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_o <= '0;
        else if (stall_o && (stall_cnt_o != 16'hFFFF))
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule
